pc_fetch_stage: RTL and testbench
=================================

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Rst  input  1  SHALL be the reset: asynchronous, active-low (Rst=0 resets).
REQ-004 pc_plus4_in  input  32  SHALL be the sequential next PC, from the downstream 32-bit adder (pc_out + 4).
REQ-005 instr_in  input  32  SHALL be the instruction word read from instruction memory at pc_out.
REQ-006 stall  input  1  SHALL be the hazard-unit request to hold the PC and IF/ID contents.
REQ-007 branch_taken  input  1 and branch_target  input  32 SHALL be the resolved branch redirect.
REQ-008 jump  input  1 and jump_target  input  32 SHALL be the resolved jump redirect.
REQ-009 pc_out  output  32  SHALL be the current PC, feeding instruction memory and the adder's in_a.
REQ-010 ifid_instr  output  32, ifid_pc4  output  32, ifid_valid  output  1 SHALL be the IF/ID pipeline register.
REQ-011 fetch_count  output  16  SHALL count instructions delivered to IF/ID.
REQ-012 state  output  2  SHALL expose the FSM state: BOOT=2'b00, RUN=2'b01, FLUSH=2'b10.

Function
REQ-013 Next-PC priority SHALL be: jump > branch_taken > stall > sequential.
REQ-014 jump=1: pc_out <= jump_target next edge, in any state, regardless of stall.
REQ-015 jump=0, branch_taken=1: pc_out <= branch_target next edge, regardless of stall.
REQ-016 No redirect, stall=1: pc_out, ifid_instr, ifid_pc4, ifid_valid, fetch_count SHALL hold.
REQ-017 No redirect, stall=0, state RUN or FLUSH: pc_out <= pc_plus4_in; ifid_instr <= instr_in; ifid_pc4 <= pc_plus4_in; ifid_valid <= 1.
REQ-018 Redirect cycle: ifid_valid <= 0 (bubble) next edge; ifid_instr/ifid_pc4 SHALL hold.
REQ-019 BOOT: entered on reset; pc_out holds RESET_PC, ifid_valid stays 0; next edge -> RUN unless redirect (-> FLUSH) or stall (stay BOOT).
REQ-020 RUN: redirect -> FLUSH; otherwise stay RUN.
REQ-021 FLUSH: lasts exactly one cycle and SHALL behave as RUN for capture; redirect -> FLUSH again; otherwise -> RUN.
REQ-022 fetch_count SHALL increment by 1 on each edge where ifid_valid is loaded with 1, and SHALL saturate at 16'hFFFF (no wrap).
REQ-023 pc_out SHALL be used unmodified (no alignment masking); pc_plus4_in wrap from 32'hFFFF_FFFC to 32'h0000_0000 SHALL be accepted as-is.
REQ-024 Combinational paths from inputs to outputs SHALL NOT exist; all outputs are registered.

Reset
REQ-025 Rst=0 SHALL immediately, without a clock edge, set pc_out=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, fetch_count=0, state=BOOT.
REQ-026 Reset asserted mid-operation (including FLUSH or stall) SHALL override all inputs and discard pending redirects.
REQ-027 After Rst rises, the first edge SHALL leave BOOT per REQ-019.

Verification
REQ-028 Reset release, stall=0, instr_in=32'hAAAA_0000+pc -> edge1 state=RUN, pc_out=0; edge2 pc_out=4, ifid_pc4=4, ifid_instr=32'hAAAA_0000, ifid_valid=1, fetch_count=1.
REQ-029 In RUN at pc_out=8, stall=1 for 3 edges -> pc_out=8, IF/ID and fetch_count unchanged; stall=0 -> pc_out=12 next edge.
REQ-030 In RUN at pc_out=16, branch_taken=1, branch_target=32'h100 together with stall=1 -> pc_out=32'h100, ifid_valid=0, state=FLUSH; next edge state=RUN, ifid_valid=1, ifid_pc4=32'h104.
REQ-031 jump=1 (jump_target=32'h400) and branch_taken=1 (branch_target=32'h200) same cycle -> pc_out=32'h400; back-to-back redirects keep state=FLUSH and ifid_valid=0.
REQ-032 Preload fetch_count to 16'hFFFE via 2 runs... drive 65537 unstalled fetches -> fetch_count stops at 16'hFFFF; Rst=0 asynchronously between edges -> all outputs reset values immediately.
REQ-033 RESET_PC=32'hBFC0_0000 instance -> pc_out=32'hBFC0_0000 during and one edge after reset, then 32'hBFC0_0004.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: holds the PC, selects the next PC (jump > branch > stall > sequential),
// and loads the IF/ID pipeline register. A small BOOT/RUN/FLUSH FSM sequences the start-up and redirect bubbles.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] pc_plus4_in,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_out,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [15:0] fetch_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        redirect;
    logic        capture;
    logic [31:0] redirect_pc;

    assign redirect = jump | branch_taken;
    assign state    = state_q;

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; FLUSH never lasts more than one cycle unless re-redirected
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: begin
                if (redirect) begin
                    state_d = FLUSH;
                end else if (stall) begin
                    state_d = BOOT;
                end else begin
                    state_d = RUN;
                end
            end
            RUN, FLUSH: begin
                state_d = redirect ? FLUSH : RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    // Control outputs: BOOT spends its one cycle presenting RESET_PC without capturing
    always_comb begin
        capture     = 1'b0;
        redirect_pc = jump ? jump_target : branch_target;
        if (!redirect && !stall && (state_q != BOOT)) begin
            capture = 1'b1;
        end
    end

    // PC register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pc_out <= RESET_PC;
        end else if (redirect) begin
            pc_out <= redirect_pc;
        end else if (capture) begin
            pc_out <= pc_plus4_in;
        end
    end

    // IF/ID register and delivered-instruction counter
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ifid_instr  <= 32'h0;
            ifid_pc4    <= 32'h0;
            ifid_valid  <= 1'b0;
            fetch_count <= 16'h0;
        end else if (redirect) begin
            ifid_valid <= 1'b0;
        end else if (capture) begin
            ifid_instr <= instr_in;
            ifid_pc4   <= pc_plus4_in;
            ifid_valid <= 1'b1;
            if (fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: a directed vector table for the main pipeline flow,
// then hand-written sequences for boot corners, asynchronous reset, counter saturation and RESET_PC.
module tb_pc_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [15:0] fetch_count;
    logic [1:0]  state;

    logic [31:0] pc2;
    logic [31:0] pc2_plus4;
    logic [31:0] ifid_instr2;
    logic [31:0] ifid_pc42;
    logic        ifid_valid2;
    logic [15:0] fetch_count2;
    logic [1:0]  state2;

    int checks = 0;
    int errors = 0;

    // Environment: external adder and an instruction memory returning AAAA_0000 + address
    assign pc_plus4  = pc + 32'd4;
    assign instr     = 32'hAAAA_0000 + pc;
    assign pc2_plus4 = pc2 + 32'd4;

    pc_fetch_stage u_dut (
        .Clk           (clk),
        .Rst           (rst_n),
        .pc_plus4_in   (pc_plus4),
        .instr_in      (instr),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc_out        (pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
        .fetch_count   (fetch_count),
        .state         (state)
    );

    pc_fetch_stage #(.RESET_PC(32'hBFC0_0000)) u_dut_boot (
        .Clk           (clk),
        .Rst           (rst_n),
        .pc_plus4_in   (pc2_plus4),
        .instr_in      (32'h0),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (32'h0),
        .jump          (1'b0),
        .jump_target   (32'h0),
        .pc_out        (pc2),
        .ifid_instr    (ifid_instr2),
        .ifid_pc4      (ifid_pc42),
        .ifid_valid    (ifid_valid2),
        .fetch_count   (fetch_count2),
        .state         (state2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        branch;
        logic [31:0] bt;
        logic        jump;
        logic [31:0] jt;
        logic [31:0] pc;
        logic [1:0]  st;
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt,
                                input logic [31:0] epc, input logic [1:0] est, input logic ev,
                                input logic [31:0] epc4, input logic [31:0] ein, input logic [15:0] ecnt);
        vec_t v;
        v.stall = s;  v.branch = b; v.bt = bt; v.jump = j; v.jt = jt;
        v.pc = epc;   v.st = est;   v.valid = ev;
        v.pc4 = epc4; v.instr = ein; v.cnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] epc, input logic [1:0] est,
                             input logic ev, input logic [31:0] epc4, input logic [31:0] ein,
                             input logic [15:0] ecnt);
        check({tag, ".pc"},    pc,                    epc);
        check({tag, ".state"}, {30'h0, state},        {30'h0, est});
        check({tag, ".valid"}, {31'h0, ifid_valid},   {31'h0, ev});
        check({tag, ".pc4"},   ifid_pc4,              epc4);
        check({tag, ".instr"}, ifid_instr,            ein);
        check({tag, ".count"}, {16'h0, fetch_count},  {16'h0, ecnt});
    endtask

    // Driver tasks
    task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
        stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1 check_all(tag, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 16'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        //             st br bt        j  jt          pc            st    v  pc4           instr          cnt
        vecs[0]  = mk(0, 0, 32'h0,   0, 32'h0,   32'h0,        2'b01, 0, 32'h0,        32'h0,         16'd0);
        vecs[1]  = mk(0, 0, 32'h0,   0, 32'h0,   32'h4,        2'b01, 1, 32'h4,        32'hAAAA_0000, 16'd1);
        vecs[2]  = mk(0, 0, 32'h0,   0, 32'h0,   32'h8,        2'b01, 1, 32'h8,        32'hAAAA_0004, 16'd2);
        vecs[3]  = mk(1, 0, 32'h0,   0, 32'h0,   32'h8,        2'b01, 1, 32'h8,        32'hAAAA_0004, 16'd2);
        vecs[4]  = mk(1, 0, 32'h0,   0, 32'h0,   32'h8,        2'b01, 1, 32'h8,        32'hAAAA_0004, 16'd2);
        vecs[5]  = mk(1, 0, 32'h0,   0, 32'h0,   32'h8,        2'b01, 1, 32'h8,        32'hAAAA_0004, 16'd2);
        vecs[6]  = mk(0, 0, 32'h0,   0, 32'h0,   32'hC,        2'b01, 1, 32'hC,        32'hAAAA_0008, 16'd3);
        vecs[7]  = mk(0, 0, 32'h0,   0, 32'h0,   32'h10,       2'b01, 1, 32'h10,       32'hAAAA_000C, 16'd4);
        vecs[8]  = mk(1, 1, 32'h100, 0, 32'h0,   32'h100,      2'b10, 0, 32'h10,       32'hAAAA_000C, 16'd4);
        vecs[9]  = mk(0, 0, 32'h0,   0, 32'h0,   32'h104,      2'b01, 1, 32'h104,      32'hAAAA_0100, 16'd5);
        vecs[10] = mk(0, 1, 32'h200, 1, 32'h400, 32'h400,      2'b10, 0, 32'h104,      32'hAAAA_0100, 16'd5);
        vecs[11] = mk(0, 1, 32'h200, 0, 32'h0,   32'h200,      2'b10, 0, 32'h104,      32'hAAAA_0100, 16'd5);
        vecs[12] = mk(1, 0, 32'h0,   1, 32'h300, 32'h300,      2'b10, 0, 32'h104,      32'hAAAA_0100, 16'd5);
        vecs[13] = mk(1, 0, 32'h0,   0, 32'h0,   32'h300,      2'b01, 0, 32'h104,      32'hAAAA_0100, 16'd5);
        vecs[14] = mk(0, 0, 32'h0,   0, 32'h0,   32'h304,      2'b01, 1, 32'h304,      32'hAAAA_0300, 16'd6);
        vecs[15] = mk(0, 0, 32'h0,   1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 2'b10, 0, 32'h304, 32'hAAAA_0300, 16'd6);
        vecs[16] = mk(0, 0, 32'h0,   0, 32'h0,   32'h0,        2'b01, 1, 32'h0,        32'hAAA9_FFFC, 16'd7);
        vecs[17] = mk(0, 0, 32'h0,   0, 32'h0,   32'h4,        2'b01, 1, 32'h4,        32'hAAAA_0000, 16'd8);

        // Reset state, held across an edge
        step();
        check_all("reset", 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 16'h0);
        check("boot_pc.in_reset", pc2, 32'hBFC0_0000);

        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].stall, vecs[i].branch, vecs[i].bt, vecs[i].jump, vecs[i].jt);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].st, vecs[i].valid,
                      vecs[i].pc4, vecs[i].instr, vecs[i].cnt);
            if (i == 0) check("boot_pc.edge1", pc2, 32'hBFC0_0000);
            if (i == 1) check("boot_pc.edge2", pc2, 32'hBFC0_0004);
        end

        // Reset in FLUSH with a redirect pending; reset must win over the redirect
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h500);
        step();
        check_all("pre_rst_flush", 32'h500, 2'b10, 1'b0, 32'h4, 32'hAAAA_0000, 16'd8);
        async_reset_check("async_rst_flush");
        step();
        check_all("rst_held_jump", 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 16'h0);

        // BOOT with stall stays in BOOT, then a redirect out of BOOT goes to FLUSH
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b1;
        step();
        check_all("boot_stall", 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 16'h0);
        drive(1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        step();
        check_all("boot_branch", 32'h80, 2'b10, 1'b0, 32'h0, 32'h0, 16'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        check_all("boot_flush_cap", 32'h84, 2'b01, 1'b1, 32'h84, 32'hAAAA_0080, 16'h1);

        // Counter saturation: after reset, edge k (k>=2) has delivered k-1 instructions
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 65538; k++) begin
            step();
            if (k == 65535) check("count_fffe", {16'h0, fetch_count}, 32'h0000_FFFE);
            if (k == 65536) check("count_ffff", {16'h0, fetch_count}, 32'h0000_FFFF);
            if (k == 65538) check("count_sat",  {16'h0, fetch_count}, 32'h0000_FFFF);
        end
        check("sat_valid", {31'h0, ifid_valid}, 32'h1);
        async_reset_check("async_rst_sat");
        check("boot_pc.async", pc2, 32'hBFC0_0000);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
